// File: rtl/reg_file_wr_arbiter.sv
// Register-file write-port arbiter: two buffered writeback requesters, round-robin with same-register ordering.
// Optional build macro REG_FILE_ARB_COALESCE_EN: drop the older of two same-register entries instead of issuing both.
module reg_file_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_reg,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  collision
);

    // Holding buffers; holdN_age set means this entry is the younger of the two.
    logic                  hold0_valid, hold1_valid;
    logic                  hold0_age, hold1_age;
    logic [ADDR_WIDTH-1:0] hold0_reg, hold1_reg;
    logic [DATA_WIDTH-1:0] hold0_data, hold1_data;
    logic                  rr;

    logic                  grant0, grant1, grant_any;
    logic                  issue_sel;
    logic                  contested, same_reg;
    logic [ADDR_WIDTH-1:0] issue_reg;
    logic [DATA_WIDTH-1:0] issue_data;
    logic                  load0, load1;
    logic                  keep0, keep1;
    logic                  age0_next, age1_next;

    // Grant decision depends only on buffered state, never on incoming valids.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        issue_sel = 1'b0;
        contested = hold0_valid & hold1_valid;
        same_reg  = (hold0_reg == hold1_reg) && (hold0_reg != '0);
        if (contested) begin
            if (same_reg) begin
`ifdef REG_FILE_ARB_COALESCE_EN
                grant0    = 1'b1;
                grant1    = 1'b1;
                issue_sel = hold0_age ? 1'b0 : 1'b1;
`else
                if (hold0_age) begin
                    grant1    = 1'b1;
                    issue_sel = 1'b1;
                end else begin
                    grant0    = 1'b1;
                end
`endif
            end else if (rr) begin
                grant1    = 1'b1;
                issue_sel = 1'b1;
            end else begin
                grant0    = 1'b1;
            end
        end else if (hold0_valid) begin
            grant0 = 1'b1;
        end else if (hold1_valid) begin
            grant1    = 1'b1;
            issue_sel = 1'b1;
        end
    end

    assign grant_any  = grant0 | grant1;
    assign issue_reg  = issue_sel ? hold1_reg  : hold0_reg;
    assign issue_data = issue_sel ? hold1_data : hold0_data;

    assign req0_ready = !rst && (!hold0_valid || grant0);
    assign req1_ready = !rst && (!hold1_valid || grant1);
    assign load0      = req0_valid & req0_ready;
    assign load1      = req1_valid & req1_ready;
    assign keep0      = hold0_valid & ~grant0;
    assign keep1      = hold1_valid & ~grant1;

    // Age tracking: a load next to a surviving entry makes the loader the younger one.
    always_comb begin
        age0_next = hold0_age & ~grant0;
        age1_next = hold1_age & ~grant1;
        if (load0 && load1) begin
            age0_next = 1'b0;
            age1_next = 1'b1;
        end else if (load0) begin
            age0_next = keep1;
            age1_next = 1'b0;
        end else if (load1) begin
            age1_next = keep0;
            age0_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0_valid <= 1'b0;
            hold0_reg   <= '0;
            hold0_data  <= '0;
        end else if (load0) begin
            hold0_valid <= 1'b1;
            hold0_reg   <= req0_reg;
            hold0_data  <= req0_data;
        end else if (grant0) begin
            hold0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold1_valid <= 1'b0;
            hold1_reg   <= '0;
            hold1_data  <= '0;
        end else if (load1) begin
            hold1_valid <= 1'b1;
            hold1_reg   <= req1_reg;
            hold1_data  <= req1_data;
        end else if (grant1) begin
            hold1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0_age <= 1'b0;
            hold1_age <= 1'b0;
            rr        <= 1'b0;
        end else begin
            hold0_age <= age0_next;
            hold1_age <= age1_next;
            if (contested) begin
                rr <= ~issue_sel;
            end
        end
    end

    // x0 consumes the slot but never reaches the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            collision <= 1'b0;
        end else begin
            wr_en     <= grant_any && (issue_reg != '0);
            collision <= contested & same_reg;
            if (grant_any && (issue_reg != '0)) begin
                wr_reg  <= issue_reg;
                wr_data <= issue_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Self-checking bench for reg_file_wr_arbiter: directed scenarios plus random traffic against a sequence-number model.
module tb_reg_file_wr_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_reg, req1_reg;
    logic [DW-1:0] req0_data, req1_data;
    logic          wr_en, collision;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;

    reg_file_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .collision(collision)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each pending entry carries its arrival number; older = smaller number.
    bit            mv[2];
    logic [AW-1:0] mreg[2];
    logic [DW-1:0] mdata[2];
    int            mseq[2];
    int            mwait[2];
    int            mlast;
    int            seqc;
    int            maxwait;
    int            nacc;
    int            col_seen;
    logic          exp_en, exp_col;
    logic [AW-1:0] exp_reg;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] log_reg[$];
    logic [DW-1:0] log_data[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mv[0] = 1'b0; mv[1] = 1'b0;
        mwait[0] = 0; mwait[1] = 0;
        mlast = 1;
        exp_en = 1'b0; exp_col = 1'b0;
        exp_reg = '0; exp_data = '0;
    endtask

    // One clock: check outputs, drive inputs, advance the model across the edge.
    task automatic tick(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1);
        bit   g[2];
        bit   rdy[2];
        bit   vin[2];
        logic [AW-1:0] rin[2];
        logic [DW-1:0] din[2];
        int   iss;
        int   older;
        bit   same;
        g[0] = 1'b0; g[1] = 1'b0; iss = 0;
        same = mv[0] && mv[1] && (mreg[0] == mreg[1]) && (mreg[0] != '0);
        if (mv[0] && mv[1]) begin
            if (same) begin
                older = (mseq[0] < mseq[1]) ? 0 : 1;
`ifdef REG_FILE_ARB_COALESCE_EN
                g[0] = 1'b1; g[1] = 1'b1; iss = 1 - older;
`else
                g[older] = 1'b1; iss = older;
`endif
            end else begin
                iss = 1 - mlast;
                g[iss] = 1'b1;
            end
        end else if (mv[0]) begin
            g[0] = 1'b1; iss = 0;
        end else if (mv[1]) begin
            g[1] = 1'b1; iss = 1;
        end
        rdy[0] = !mv[0] || g[0];
        rdy[1] = !mv[1] || g[1];

        chk("ready0", 64'(req0_ready), 64'(rdy[0]));
        chk("ready1", 64'(req1_ready), 64'(rdy[1]));
        chk("wr_en", 64'(wr_en), 64'(exp_en));
        chk("wr_reg", 64'(wr_reg), 64'(exp_reg));
        chk("wr_data", 64'(wr_data), 64'(exp_data));
        chk("collision", 64'(collision), 64'(exp_col));
        if (wr_en === 1'b1) begin
            log_reg.push_back(wr_reg);
            log_data.push_back(wr_data);
        end
        if (collision === 1'b1) col_seen++;

        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        vin[0] = v0; rin[0] = r0; din[0] = d0;
        vin[1] = v1; rin[1] = r1; din[1] = d1;

        if ((g[0] || g[1]) && mreg[iss] != '0) begin
            exp_en = 1'b1; exp_reg = mreg[iss]; exp_data = mdata[iss];
        end else begin
            exp_en = 1'b0;
        end
        exp_col = same;
        if (mv[0] && mv[1]) mlast = iss;
        for (int n = 0; n < 2; n++) begin
            if (mv[n] && !g[n]) begin
                mwait[n]++;
                if (mwait[n] > maxwait) maxwait = mwait[n];
            end
            if (g[n]) mv[n] = 1'b0;
        end
        for (int n = 0; n < 2; n++) begin
            if (vin[n] && rdy[n]) begin
                mv[n] = 1'b1; mreg[n] = rin[n]; mdata[n] = din[n];
                mseq[n] = seqc; seqc++; mwait[n] = 0;
                if (rin[n] != '0) nacc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        chk("rst_ready1", 64'(req1_ready), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_wr_en_edge", 64'(wr_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("post_rst_ready0", 64'(req0_ready), 64'd1);
        chk("post_rst_ready1", 64'(req1_ready), 64'd1);
    endtask

    initial begin
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] da, db;
        int            base_acc;
        rst = 1'b1;
        req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
        req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
        seqc = 0; maxwait = 0; nacc = 0; col_seen = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_wr_reg", 64'(wr_reg), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_ready0", 64'(req0_ready), 64'd0);
        chk("reset_ready1", 64'(req1_ready), 64'd0);
        rst = 1'b0;
        #1;

        // Solo stream on req0.
        log_reg.delete(); log_data.delete();
        for (int i = 0; i < 4; i++) tick(1'b1, AW'(5 + i), DW'(32'hA0 + i), 1'b0, '0, '0);
        idle(3);
        chk("solo_count", 64'(log_reg.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_reg.size(); i++) begin
            chk("solo_reg", 64'(log_reg[i]), 64'(5 + i));
            chk("solo_data", 64'(log_data[i]), 64'(32'hA0 + i));
        end

        // Continuous contention on distinct registers.
        log_reg.delete(); log_data.delete();
        for (int i = 0; i < 6; i++) tick(1'b1, AW'(1), DW'(32'h11), 1'b1, AW'(2), DW'(32'h22));
        for (int i = 0; i < 6 && i < log_reg.size(); i++)
            chk("contend_alt", 64'(log_reg[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        chk("contend_count", 64'(log_reg.size()), 64'd4);

        // Reset in the middle of traffic; buffered writes vanish.
        do_reset();
        log_reg.delete(); log_data.delete();
        idle(3);
        chk("post_rst_no_write", 64'(log_reg.size()), 64'd0);

        // Same register from both sides, req0 older.
        log_reg.delete(); log_data.delete();
        col_seen = 0;
        tick(1'b1, AW'(1), DW'(32'h11), 1'b1, AW'(2), DW'(32'h22));
        tick(1'b1, AW'(3), DW'(32'hA), 1'b0, '0, '0);
        tick(1'b0, '0, '0, 1'b1, AW'(3), DW'(32'hB));
        idle(4);
        chk("samereg_collision", 64'(col_seen), 64'd1);
`ifdef REG_FILE_ARB_COALESCE_EN
        chk("samereg_count", 64'(log_reg.size()), 64'd3);
        if (log_reg.size() >= 3) begin
            chk("samereg_last_reg", 64'(log_reg[2]), 64'd3);
            chk("samereg_last_data", 64'(log_data[2]), 64'hB);
        end
`else
        chk("samereg_count", 64'(log_reg.size()), 64'd4);
        if (log_reg.size() >= 4) begin
            chk("samereg_first_data", 64'(log_data[2]), 64'hA);
            chk("samereg_second_data", 64'(log_data[3]), 64'hB);
            chk("samereg_second_reg", 64'(log_reg[3]), 64'd3);
        end
`endif

        // x0 drains without a write; following write proceeds.
        log_reg.delete(); log_data.delete();
        tick(1'b1, AW'(0), DW'(32'hFFFF_FFFF), 1'b0, '0, '0);
        tick(1'b1, AW'(4), DW'(32'h44), 1'b0, '0, '0);
        idle(3);
        chk("x0_count", 64'(log_reg.size()), 64'd1);
        if (log_reg.size() >= 1) chk("x0_next_data", 64'(log_data[0]), 64'h44);

        // Random backpressure, distinct register ranges per side.
        log_reg.delete(); log_data.delete();
        maxwait = 0;
        base_acc = nacc;
        for (int i = 0; i < 100; i++) begin
            ra = AW'($urandom_range(1, 15));
            rb = AW'($urandom_range(16, 31));
            da = DW'($urandom);
            db = DW'($urandom);
            tick($urandom_range(0, 3) != 0, ra, da, $urandom_range(0, 3) != 0, rb, db);
        end
        idle(4);
        chk("bp_no_loss", 64'(log_reg.size()), 64'(nacc - base_acc));
        chk("bp_max_wait_le1", 64'(maxwait <= 1), 64'd1);

        // Fully random traffic over a tiny register range (x0 and collisions included).
        for (int i = 0; i < 300; i++) begin
            ra = AW'($urandom_range(0, 3));
            rb = AW'($urandom_range(0, 3));
            da = DW'($urandom);
            db = DW'($urandom);
            tick($urandom_range(0, 1) != 0, ra, da, $urandom_range(0, 1) != 0, rb, db);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
